// File: rtl/unformatter.sv
// Padding remover: buffers one block, scans backwards for the 0x01 marker, then streams words with byte validity.
// Optional byte-count output blk_len is enabled by defining UNFORMATTER_LEN_EN.
module unformatter #(
  parameter int SIZE        = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_pad,
  input  logic                  din_final,
  output logic [SIZE-1:0]       dout,
  output logic [SIZE/8-1:0]     dout_validity,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  pad_err
`ifdef UNFORMATTER_LEN_EN
  ,
  output logic [$clog2(SIZE/8*BLOCK_WORDS+1)-1:0] blk_len
`endif
);

  localparam int NB  = SIZE / 8;
  localparam int WCW = $clog2(BLOCK_WORDS);
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW  = $clog2(NB * BLOCK_WORDS + 1);

  typedef logic [WCW-1:0] widx_t;
  localparam widx_t TOP = widx_t'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {FILL, SCAN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] buffer [BLOCK_WORDS];
  widx_t           wcnt, k, last_idx, ocnt;
  logic            pad_q, final_q;
  logic [BW-1:0]   mark_b;

  logic [SIZE-1:0] cur;
  logic            cur_zero;
  logic [BW-1:0]   hb;
  logic [7:0]      hv;
  logic            in_acc, out_acc, scan_err, load, ld_pad;
  widx_t           ld_idx, ld_last;
  logic [BW-1:0]   ld_b;
  logic [NB-1:0]   ld_mask;
  logic [SIZE-1:0] ld_data;
  logic            ld_lastflag;

  function automatic logic [NB-1:0] low_mask(input logic [BW-1:0] b);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i] = (BW'(i) < b);
    return m;
  endfunction

  function automatic logic [SIZE-1:0] byte_expand(input logic [NB-1:0] m);
    logic [SIZE-1:0] e;
    e = '0;
    for (int i = 0; i < NB; i++) e[i*8 +: 8] = {8{m[i]}};
    return e;
  endfunction

  assign din_ready = (state == FILL);
  assign in_acc    = din_valid && din_ready;
  assign out_acc   = dout_valid && dout_ready;

  // Highest nonzero byte of the word under examination
  always_comb begin
    cur      = buffer[k];
    cur_zero = (cur == '0);
    hb       = '0;
    hv       = '0;
    for (int i = 0; i < NB; i++) begin
      if (cur[i*8 +: 8] != 8'h00) begin
        hb = BW'(i);
        hv = cur[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    scan_err  = 1'b0;
    ld_idx    = '0;
    ld_last   = TOP;
    ld_pad    = 1'b0;
    ld_b      = '0;
    case (state)
      FILL: begin
        if (in_acc && wcnt == TOP) begin
          if (pad_q) begin
            state_nxt = SCAN;
          end else begin
            state_nxt = DRAIN;
            load      = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cur_zero) begin
          if (k == '0) begin
            scan_err  = 1'b1;
            state_nxt = FILL;
          end
        end else if (hv == 8'h01) begin
          state_nxt = DRAIN;
          load      = 1'b1;
          ld_last   = k;
          ld_pad    = 1'b1;
          ld_b      = hb;
        end else begin
          scan_err  = 1'b1;
          state_nxt = FILL;
        end
      end
      DRAIN: begin
        if (out_acc) begin
          if (ocnt == last_idx) begin
            state_nxt = FILL;
          end else begin
            load    = 1'b1;
            ld_idx  = ocnt + 1'b1;
            ld_last = last_idx;
            ld_pad  = pad_q;
            ld_b    = mark_b;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign ld_mask     = (ld_pad && ld_idx == ld_last) ? low_mask(ld_b) : '1;
  assign ld_data     = buffer[ld_idx] & byte_expand(ld_mask);
  assign ld_lastflag = (ld_idx == ld_last) && (pad_q || final_q);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (in_acc) buffer[wcnt] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt          <= '0;
      k             <= '0;
      last_idx      <= '0;
      ocnt          <= '0;
      pad_q         <= 1'b0;
      final_q       <= 1'b0;
      mark_b        <= '0;
      dout          <= '0;
      dout_validity <= '0;
      dout_valid    <= 1'b0;
      dout_last     <= 1'b0;
      pad_err       <= 1'b0;
`ifdef UNFORMATTER_LEN_EN
      blk_len       <= '0;
`endif
    end else begin
      pad_err <= scan_err;
      if (in_acc) begin
        wcnt <= (wcnt == TOP) ? '0 : wcnt + 1'b1;
        if (wcnt == '0) begin
          pad_q   <= din_pad;
          final_q <= din_final;
        end
      end
      if (state == FILL && state_nxt == SCAN) k <= TOP;
      else if (state == SCAN && cur_zero)     k <= k - 1'b1;
      // Output registers only move on DRAIN entry or a completed handshake
      if (load) begin
        dout          <= ld_data;
        dout_validity <= ld_mask;
        dout_last     <= ld_lastflag;
        dout_valid    <= 1'b1;
        ocnt          <= ld_idx;
      end else if (out_acc) begin
        dout_valid <= 1'b0;
      end
      if (state != DRAIN && state_nxt == DRAIN) begin
        last_idx <= ld_last;
        mark_b   <= ld_b;
`ifdef UNFORMATTER_LEN_EN
        blk_len  <= ld_pad ? LW'(ld_last) * LW'(NB) + LW'(ld_b) : LW'(NB * BLOCK_WORDS);
`endif
      end
    end
  end

endmodule

// File: tb/tb_unformatter.sv
// Scoreboard bench for unformatter: randomized and directed blocks against a byte-level padding model.
module tb_unformatter;
  localparam int SIZE = 32;
  localparam int BWD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid, din_ready, din_pad, din_final;
  logic [31:0] dout;
  logic [3:0]  dout_validity;
  logic        dout_valid, dout_ready, dout_last, pad_err;
`ifdef UNFORMATTER_LEN_EN
  logic [4:0]  blk_len;
`endif

  always #5 clk = ~clk;

  unformatter #(.SIZE(SIZE), .BLOCK_WORDS(BWD)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .din_pad(din_pad), .din_final(din_final), .dout(dout), .dout_validity(dout_validity),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last), .pad_err(pad_err)
`ifdef UNFORMATTER_LEN_EN
    , .blk_len(blk_len)
`endif
  );

  typedef struct {
    bit          err;
    logic [31:0] d;
    logic [3:0]  m;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rdy_force = 1'b1;
  bit          rdy_val = 1'b1;
  bit          held = 1'b0;
  bit          prev_err = 1'b0;
  logic [31:0] hd;
  logic [3:0]  hm;
  logic        hl;
  exp_t        me;
  logic [31:0] blk [4];
  bit          bpad, bfin;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: forced or random, updated just after each rising edge
  initial begin
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      dout_ready = rdy_force ? rdy_val : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every output handshake or pad_err pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held     = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (held && dout_valid) begin
          chk("hold_data", 64'(dout), 64'(hd));
          chk("hold_mask", 64'(dout_validity), 64'(hm));
          chk("hold_last", 64'(dout_last), 64'(hl));
        end
        held = dout_valid && !dout_ready;
        hd = dout; hm = dout_validity; hl = dout_last;
        if (pad_err) begin
          chk("pad_err_one_cycle", 64'(prev_err), 64'(0));
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_pad_err: got pad_err=1 expected no event");
          end else begin
            me = sb.pop_front();
            chk("event_is_err", 64'(1), 64'(me.err));
          end
        end
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_word: got dout=%0h expected no word", dout);
          end else begin
            me = sb.pop_front();
            chk("event_is_word", 64'(0), 64'(me.err));
            chk("dout", 64'(dout), 64'(me.d));
            chk("dout_validity", 64'(dout_validity), 64'(me.m));
            chk("dout_last", 64'(dout_last), 64'(me.last));
          end
        end
        prev_err = pad_err;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_dout_valid", 64'(dout_valid), 64'(0));
    chk("rst_din_ready", 64'(din_ready), 64'(1));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_validity", 64'(dout_validity), 64'(0));
    chk("rst_last", 64'(dout_last), 64'(0));
    chk("rst_pad_err", 64'(pad_err), 64'(0));
  endtask

  // Model: treat block as a flat byte string, strip trailing zeros and the 0x01 marker
  task automatic issue(input logic [31:0] w [4], input bit pad, input bit fin);
    logic [7:0]  by [16];
    exp_t        e;
    int          j, lat, exp_lat, exp_len, n, g;
    bit          exp_err;
    for (int i = 0; i < 16; i++) by[i] = w[i/4][(i%4)*8 +: 8];
    exp_len = 16;
    if (pad) begin
      j = -1;
      for (int i = 0; i < 16; i++) if (by[i] != 8'h00) j = i;
      if (j < 0) exp_err = 1'b1;
      else       exp_err = (by[j] != 8'h01);
      exp_lat = (j < 0) ? 4 : 4 - j / 4;
      if (exp_err) begin
        e.err = 1'b1; e.d = '0; e.m = '0; e.last = 1'b0;
        sb.push_back(e);
      end else begin
        exp_len = j;
        for (int wi = 0; wi <= j / 4; wi++) begin
          e.err = 1'b0; e.d = '0; e.m = '0;
          for (int bi = 0; bi < 4; bi++) begin
            g = wi * 4 + bi;
            if (g < j) begin
              e.m[bi] = 1'b1;
              e.d[bi*8 +: 8] = by[g];
            end
          end
          e.last = (wi == j / 4);
          sb.push_back(e);
        end
      end
    end else begin
      exp_err = 1'b0;
      exp_lat = 0;
      for (int wi = 0; wi < 4; wi++) begin
        e.err = 1'b0; e.d = w[wi]; e.m = 4'hF; e.last = fin && (wi == 3);
        sb.push_back(e);
      end
    end
    for (int wi = 0; wi < 4; wi++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      din       = w[wi];
      din_pad   = (wi == 0) ? pad : 1'($urandom);
      din_final = (wi == 0) ? fin : 1'($urandom);
      din_valid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (din_ready) break;
        n++;
        if (n > 300) begin
          $display("FAIL din_handshake_timeout: got din_ready=0 expected 1");
          $fatal(1, "input handshake never completed");
        end
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      din       = $urandom;
      din_pad   = 1'($urandom);
      din_final = 1'($urandom);
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (dout_valid || pad_err) break;
      lat++;
      if (lat > 20) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("outcome_is_err", 64'(pad_err), 64'(exp_err));
`ifdef UNFORMATTER_LEN_EN
    if (!exp_err) chk("blk_len", 64'(blk_len), 64'(exp_len));
`else
    if (exp_len < 0) $display("negative length");
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!din_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("block_done", 64'(din_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [31:0] w [4], input bit pad, input bit fin);
    issue(w, pad, fin);
    wait_done();
  endtask

  task automatic gen_rand(output logic [31:0] w [4], output bit pad, output bit fin);
    logic [7:0] by [16];
    int         r, len;
    r = int'($urandom_range(0, 9));
    fin = 1'($urandom);
    pad = (r >= 4);
    if (!pad) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom;
    end else begin
      len = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) by[i] = (i < len) ? 8'($urandom) : 8'h00;
      by[len] = 8'h01;
      if (r == 8) by[len] = 8'($urandom_range(2, 255));
      if (r == 9 && len < 3) for (int i = 0; i < 16; i++) by[i] = 8'h00;
      for (int i = 0; i < 16; i++) w[i/4][(i%4)*8 +: 8] = by[i];
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; din_pad = 1'b0; din_final = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    blk = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run(blk, 1'b0, 1'b0);
    rdy_force = 1'b0;
    blk = '{32'h44332211, 32'h00000155, 32'h0, 32'h0};
    run(blk, 1'b1, 1'b0);
    blk = '{32'h00000001, 32'h0, 32'h0, 32'h0};
    run(blk, 1'b1, 1'b0);
    blk = '{32'h0A0B0C0D, 32'h11223344, 32'h55667788, 32'h01AABBCC};
    run(blk, 1'b1, 1'b1);
    blk = '{32'h0, 32'h0, 32'h0, 32'h0};
    run(blk, 1'b1, 1'b0);
    blk = '{32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    run(blk, 1'b0, 1'b1);
    blk = '{32'h01020304, 32'h05060708, 32'h0, 32'h02000000};
    run(blk, 1'b1, 1'b0);
    blk = '{32'hDEADBEEF, 32'h00000001, 32'h0, 32'h0};
    run(blk, 1'b1, 1'b0);

    // Reset while word 1 of an unpadded block is pending
    rdy_force = 1'b1; rdy_val = 1'b0;
    blk = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
    issue(blk, 1'b0, 1'b0);
    @(posedge clk); #1 rdy_val = 1'b1;
    @(posedge clk); #1 rdy_val = 1'b0;
    @(negedge clk);
    chk("pending_word1_valid", 64'(dout_valid), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rdy_force = 1'b0;
    blk = '{32'h55443322, 32'h77660166, 32'h0, 32'h0};
    run(blk, 1'b1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      gen_rand(blk, bpad, bfin);
      run(blk, bpad, bfin);
    end

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
